// File: rtl/dot_acc_pkg.sv
// Shared types and constants for the dot-product accumulator.
package dot_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;

    // A job of 2^len_w-1 int32 beats can never overflow an accumulator this wide.
    function automatic bit acc_w_ok(input int acc_w, input int len_w);
        return acc_w >= (32 + len_w);
    endfunction

endpackage

// File: rtl/dot_accumulator_sat_narrow.sv
// Narrows the wide signed accumulator to int32, clamping or wrapping.
module sat_narrow
    import dot_acc_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int SAT   = 1
) (
    input  logic [ACC_W-1:0] acc,
    output logic [31:0]      result32,
    output logic             ovf
);

    // Bits 31 and up must all equal the sign bit for the value to fit in int32.
    logic [ACC_W-32:0] upper;
    assign upper = acc[ACC_W-1:31];

    // Overflow detect and optional clamp toward the sign of the true sum.
    always_comb begin
        ovf      = !((&upper) || !(|upper));
        result32 = acc[31:0];
        if ((SAT != 0) && ovf) begin
            result32 = acc[ACC_W-1] ? INT32_MIN : INT32_MAX;
        end
    end

endmodule

// File: rtl/dot_accumulator.sv
// Sums a programmed number of int32 partial dot results into one int32 result.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; len is captured with it
// ACCUM | accepting beats, cnt counts down the remaining beats
// DONE  | result presented with out_valid, held until out_ready
module dot_accumulator
    import dot_acc_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int ACC_W = 40,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic             out_ovf
);

    if (!acc_w_ok(ACC_W, LEN_W)) begin : g_bad_acc_w
        $error("dot_accumulator: ACC_W must be at least 32+LEN_W");
    end

    acc_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_next;
    logic [LEN_W-1:0] cnt;
    logic             in_ready_q;
    logic [31:0]      result_q;
    logic [31:0]      narrow_result;
    logic             narrow_ovf;
    logic             beat;

    // Only the low lane carries the partial result; the rest of the vector register is don't-care.
    logic unused_in_hi;
    assign unused_in_hi = ^in_data[127:32];

    // Abort must stop a beat being taken in its own cycle, so it gates the registered ready.
    assign in_ready = in_ready_q && !abort;
    assign beat     = in_valid && in_ready;
    assign acc_next = acc + {{(ACC_W-32){in_data[31]}}, in_data[31:0]};
    assign out_data = {96'b0, result_q};

    // Narrowing sits on the next-sum path so the last beat's result registers in the same edge.
    sat_narrow #(
        .ACC_W (ACC_W),
        .SAT   (SAT)
    ) u_sat_narrow (
        .acc      (acc_next),
        .result32 (narrow_result),
        .ovf      (narrow_ovf)
    );

    // Job sequencing, accumulation and the registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            in_ready_q <= 1'b0;
            out_valid  <= 1'b0;
            result_q   <= '0;
            out_ovf    <= 1'b0;
        end else if (abort) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            busy       <= 1'b0;
            in_ready_q <= 1'b0;
            out_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        acc  <= '0;
                        cnt  <= len;
                        if (len != '0) begin
                            state      <= ACCUM;
                            in_ready_q <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result_q  <= '0;
                            out_ovf   <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= acc_next;
                        cnt <= cnt - 1'b1;
                        if (cnt == LEN_W'(1)) begin
                            state      <= DONE;
                            in_ready_q <= 1'b0;
                            out_valid  <= 1'b1;
                            result_q   <= narrow_result;
                            out_ovf    <= narrow_ovf;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    in_ready_q <= 1'b0;
                    out_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dot_accumulator.sv
// Scoreboard bench for dot_accumulator; a saturating and a wrapping instance run in lockstep.
module tb_dot_accumulator;

    localparam int LEN_W = 8;
    localparam int ACC_W = 40;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic             in_valid = 1'b0;
    logic [127:0]     in_data = '0;
    logic             out_ready = 1'b1;

    logic             busy, in_ready, out_valid, out_ovf;
    logic [127:0]     out_data;
    logic             busy_w, in_ready_w, out_valid_w, out_ovf_w;
    logic [127:0]     out_data_w;

    typedef struct {
        logic [127:0] sat_data;
        logic [127:0] wrap_data;
        logic         ovf;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [31:0] stim_q[$];
    int          n_vec = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dot_accumulator #(.LEN_W(LEN_W), .ACC_W(ACC_W), .SAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf)
    );

    dot_accumulator #(.LEN_W(LEN_W), .ACC_W(ACC_W), .SAT(0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort), .busy(busy_w),
        .in_valid(in_valid), .in_ready(in_ready_w), .in_data(in_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w), .out_ovf(out_ovf_w)
    );

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Result monitor: every output handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("out_data_sat", out_data, mon_e.sat_data);
                check_val("out_ovf_sat", out_ovf, mon_e.ovf);
                check_val("out_valid_wrap", out_valid_w, 1);
                check_val("out_data_wrap", out_data_w, mon_e.wrap_data);
                check_val("out_ovf_wrap", out_ovf_w, mon_e.ovf);
            end
        end
    end

    // Runs one job over stim_q[0:n-1]; gapped drops in_valid every other cycle,
    // hold keeps out_ready low that many DONE cycles with a stray start pulse.
    task automatic run_job(input int n, input bit gapped, input int hold, input bit chk_lat);
        exp_t         e;
        longint       s = 0;
        int           idx = 0;
        int           cyc = 0;
        bit           fire;
        bit           done = 0;
        logic [127:0] held;
        for (int i = 0; i < n; i++) s += longint'(int'(stim_q[i]));
        e.ovf       = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        e.wrap_data = {96'b0, s[31:0]};
        if (!e.ovf)     e.sat_data = {96'b0, s[31:0]};
        else if (s < 0) e.sat_data = {96'b0, 32'h8000_0000};
        else            e.sat_data = {96'b0, 32'h7FFF_FFFF};
        exp_q.push_back(e);

        out_ready = (hold == 0);
        start     = 1'b1;
        len       = n[LEN_W-1:0];
        in_valid  = 1'b0;
        while (!done) begin
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            if (fire) idx++;
            if (out_valid) begin
                done = 1;
            end else if (cyc > 400) begin
                check_val("job_timeout", out_valid, 1);
                done = 1;
            end
            if (!done && idx < n && !(gapped && (cyc % 2 == 1))) begin
                in_valid = 1'b1;
                in_data  = {32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_5A5A, stim_q[idx]};
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        if (chk_lat) check_val("latency", cyc, n + 1);
        check_val("beats_taken", idx, n);
        check_val("in_ready_done", in_ready, 0);
        check_val("busy_done", busy, 1);

        held = out_data;
        for (int h = 0; h < hold; h++) begin
            if (h == 1) begin
                start = 1'b1;
                len   = 8'd1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            check_val("hold_data", out_data, held);
            check_val("hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_val("idle_valid", out_valid, 0);
        check_val("idle_busy", busy, 0);
        stim_q.delete();
    endtask

    initial begin
        #12;
        check_val("rst_busy", busy, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_ovf", out_ovf, 0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        stim_q = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFC};
        run_job(4, 0, 0, 1);

        run_job(0, 0, 0, 1);

        stim_q = '{32'h7FFF_FFFF, 32'h7FFF_FFFF};
        run_job(2, 0, 0, 1);

        stim_q = '{32'h8000_0000, 32'h8000_0000};
        run_job(2, 0, 0, 1);

        stim_q = '{32'd10, 32'hFFFF_FFEC, 32'd35};
        run_job(3, 1, 4, 0);

        // Abort after two of five beats, with a third beat on the bus.
        @(posedge clk); #1;
        start = 1'b1; len = 8'd5;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 128'd100;
        @(posedge clk); #1;
        in_data = 128'd200;
        @(posedge clk); #1;
        in_data = 128'd300; abort = 1'b1;
        #1;
        check_val("abort_in_ready", in_ready, 0);
        @(posedge clk); #1;
        abort = 1'b0; in_valid = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_valid", out_valid, 0);
        stim_q = '{32'd7};
        run_job(1, 0, 0, 1);

        // Asynchronous reset in the middle of a job.
        @(posedge clk); #1;
        start = 1'b1; len = 8'd3;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1; in_data = 128'd55;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_val("arst_busy", busy, 0);
        check_val("arst_in_ready", in_ready, 0);
        check_val("arst_out_valid", out_valid, 0);
        check_val("arst_out_data", out_data, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        stim_q = '{32'hFFFF_FFF6, 32'd3};
        run_job(2, 0, 0, 1);

        for (int i = 0; i < 8; i++) stim_q.push_back($urandom());
        run_job(8, 0, 0, 1);

        repeat (3) @(posedge clk);
        check_val("sb_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
